gcd_controller: RTL and testbench
=================================

# gcd_controller

Control-path FSM that sequences the 16-bit subtract-based GCD datapath. It accepts a start request and then loads operands A and B from the external data source over a valid/ready handshake. It iterates subtract steps according to the datapath's gt/lt/eq comparator flags and signals completion or timeout. It sits directly upstream of the datapath, driving its load and mux selects and consuming its compare flags. The result is left in datapath register A.

## Interface
- CNT_W, 16, width of the iteration counter and `iter_count` output
- MAX_ITER, 65535, number of subtract steps after which the run aborts with `err`
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a new GCD run; sampled only in IDLE
- in_valid  in  1  source presents an operand on the datapath `data_in` bus
- in_ready  out  1  controller accepts an operand this cycle (high in LOAD_A, LOAD_B)
- gt, lt, eq  in  1 each  datapath flags: A>B, A<B, A==B
- lda, ldb  out  1 each  datapath register load enables
- sel_1, sel_2  out  1 each  subtractor operand selects; 1 selects A, 0 selects B
- sel_in  out  1  load source select; 0 selects external `data_in`, 1 selects the subtractor output
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; GCD valid in datapath A
- err  out  1  one-cycle pulse; run aborted (timeout or invalid flags)
- iter_count  out  CNT_W  subtract steps performed in the current or last run

## Operation
- Moore FSM; all control outputs are decoded from the state only.
- Unlisted outputs are 0.
- IDLE: when `start`=1, go to LOAD_A and clear `iter_count`. A `start` seen in any other state is ignored.
- LOAD_A: `in_ready`=1, `sel_in`=0, `lda`=in_valid. Advance to LOAD_B on `in_valid`; otherwise hold.
- LOAD_B: `in_ready`=1, `sel_in`=0, `ldb`=in_valid. Advance to COMPARE on `in_valid`.
- COMPARE: no loads. Flag priority is eq > gt > lt.
  - eq: go to DONE.
  - gt: go to SUB_A.
  - lt: go to SUB_B.
  - No flag set: go to ERR.
  - If `iter_count`==MAX_ITER and eq=0: go to ERR.
- SUB_A: `sel_1`=1, `sel_2`=0, `sel_in`=1, `lda`=1 (A <= A-B). Increment `iter_count`, then return to COMPARE.
- SUB_B: `sel_1`=0, `sel_2`=1, `sel_in`=1, `ldb`=1 (B <= B-A). Increment `iter_count`, then return to COMPARE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- ERR: `err`=1 for one cycle, then go to IDLE.
- `iter_count` holds its value in IDLE until the next accepted `start`, and saturates at MAX_ITER.
- Operand edge cases:
  - A=B=0: eq on the first compare, so `done` with result 0.
  - One operand 0, the other nonzero: no progress is possible, so the run ends in `err` at MAX_ITER.

## Timing
- Reset (asynchronous assert, synchronous release) forces:
  - state=IDLE, `iter_count`=0;
  - `lda`, `ldb`, `sel_1`, `sel_2`, `sel_in`, `in_ready`, `busy`, `done`, `err` all 0.
- Reset mid-run abandons the run immediately. Datapath register contents are unspecified afterwards.
- Operand handshake: a transfer occurs on each rising edge where `in_valid`=`in_ready`=1. The source holds `data_in` stable while `in_valid`=1. Stalls of any length are allowed.
- The compare flags are valid one cycle after a register load, which is why every subtract step alternates COMPARE and SUB (2 cycles per step).
- With zero stalls, latency from the `start` cycle to the `done` cycle is 4 + 2·N cycles, where N = final `iter_count`.
- `done` and `err` are mutually exclusive and never assert in the same run. `busy` deasserts in the cycle after `done`/`err`.

## Structure
- Shared package `gcd_pkg` holds:
  - the state encoding localparams (IDLE, LOAD_A, LOAD_B, COMPARE, SUB_A, SUB_B, DONE, ERR; 3-bit);
  - the operand width (16);
  - the CNT_W default.
- One sub-module, `gcd_iter_counter`: a saturating counter with clear, increment and a terminal-count output (==MAX_ITER).
- The FSM next-state and output decode live in `gcd_controller`.

## Test plan
- Reset asserted mid-SUB_A: all outputs 0 immediately, state IDLE. After release, a new `start` runs normally.
- A=12, B=8, no stalls, `start` at cycle 0:
  - step sequence is SUB_A (A=4), then SUB_B (B=4), then eq;
  - `done` pulses at cycle 8 with `iter_count`=2 and datapath A=4.
- A=9, B=9: `done` at cycle 4 with `iter_count`=0. Repeat with A=0, B=0: `done` at cycle 4, result 0.
- A=7, B=0 with MAX_ITER=16: `err` pulses once `iter_count`=16, with no `done`. A `start` pulsed while busy has no effect.
- A=48, B=18 with `in_valid` withheld 3 cycles before each operand:
  - `in_ready` stays high throughout each stall;
  - each register loads exactly once;
  - final A=6, with `done` 6 cycles later than the unstalled case.
- Force gt=lt=eq=0 in COMPARE: ERR next cycle, `err` pulse, then IDLE.

Source files
------------

// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_pkg
//  Description : Shared definitions for the subtract-based GCD controller:
//                state encoding, operand width and the default counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package gcd_pkg;

    // Operand width of the datapath registers A and B.
    localparam int DATA_W    = 16;
    // Default width of the iteration counter.
    localparam int CNT_W_DEF = 16;

    // 3-bit state encoding.
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD_A  = 3'd1;
    localparam logic [2:0] LOAD_B  = 3'd2;
    localparam logic [2:0] COMPARE = 3'd3;
    localparam logic [2:0] SUB_A   = 3'd4;
    localparam logic [2:0] SUB_B   = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;
    localparam logic [2:0] ERR     = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = IDLE,
        ST_LOAD_A  = LOAD_A,
        ST_LOAD_B  = LOAD_B,
        ST_COMPARE = COMPARE,
        ST_SUB_A   = SUB_A,
        ST_SUB_B   = SUB_B,
        ST_DONE    = DONE,
        ST_ERR     = ERR
    } state_t;

endpackage
`default_nettype wire

// File: rtl/gcd_if.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_if
//  Description : Control/status bundle between the GCD controller and its
//                environment (operand source, datapath, requester).
//                master : controller side (drives loads, selects, status)
//                slave  : environment side (drives start, in_valid, flags)
//  Ports       : start, in_valid, gt, lt, eq           -> controller
//                in_ready, lda, ldb, sel_1, sel_2,
//                sel_in, busy, done, err, iter_count   <- controller
//  Revision    : 1.0 - initial release
// ============================================================================
interface gcd_if
    import gcd_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic             gt;
    logic             lt;
    logic             eq;
    logic             lda;
    logic             ldb;
    logic             sel_1;
    logic             sel_2;
    logic             sel_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] iter_count;

    modport master (
        input  start, in_valid, gt, lt, eq,
        output in_ready, lda, ldb, sel_1, sel_2, sel_in,
               busy, done, err, iter_count
    );

    modport slave (
        output start, in_valid, gt, lt, eq,
        input  in_ready, lda, ldb, sel_1, sel_2, sel_in,
               busy, done, err, iter_count
    );

endinterface
`default_nettype wire

// File: rtl/gcd_iter_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_iter_counter
//  Description : Saturating iteration counter with synchronous clear,
//                increment enable and terminal-count flag (count==MAX_ITER).
//  Ports       : clk, rst_n  - clock, async active-low reset
//                clear       - zero the count (priority over inc)
//                inc         - add one unless already at MAX_ITER
//                count       - current count
//                tc          - high while count == MAX_ITER
//  Revision    : 1.0 - initial release
// ============================================================================
module gcd_iter_counter #(
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 65535
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clear,
    input  wire logic             inc,
    output logic      [CNT_W-1:0] count,
    output logic                  tc
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_ITER);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != C_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign tc    = (r_count == C_MAX);

endmodule
`default_nettype wire

// File: rtl/gcd_controller.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_controller
//  Description : Moore FSM sequencing a 16-bit subtract-based GCD datapath.
//                Loads A then B over a valid/ready handshake, then alternates
//                COMPARE / SUB steps until the datapath reports A==B (done)
//                or the step budget / flag sanity check fails (err).
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - gcd_if.master control/status bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int MAX_ITER = 65535
) (
    input  wire logic clk,
    input  wire logic rst_n,
    gcd_if.master     bus
);

    state_t r_state;
    state_t w_next;

    logic w_in_ready;
    logic w_lda;
    logic w_ldb;
    logic w_sel_1;
    logic w_sel_2;
    logic w_sel_in;
    logic w_busy;
    logic w_done;
    logic w_err;

    logic             w_cnt_clear;
    logic             w_cnt_inc;
    logic             w_cnt_tc;
    logic [CNT_W-1:0] w_cnt;

    // ------------------------------------------------------------------
    // Iteration counter: cleared by an accepted start, stepped once per
    // subtract state.
    // ------------------------------------------------------------------
    assign w_cnt_clear = (r_state == ST_IDLE) && bus.start;
    assign w_cnt_inc   = (r_state == ST_SUB_A) || (r_state == ST_SUB_B);

    gcd_iter_counter #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_cnt_clear),
        .inc   (w_cnt_inc),
        .count (w_cnt),
        .tc    (w_cnt_tc)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_lda      = 1'b0;
        w_ldb      = 1'b0;
        w_sel_1    = 1'b0;
        w_sel_2    = 1'b0;
        w_sel_in   = 1'b0;
        w_busy     = 1'b1;
        w_done     = 1'b0;
        w_err      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_next = ST_LOAD_A;
                end
            end

            ST_LOAD_A: begin
                w_in_ready = 1'b1;
                w_lda      = bus.in_valid;
                if (bus.in_valid) begin
                    w_next = ST_LOAD_B;
                end
            end

            ST_LOAD_B: begin
                w_in_ready = 1'b1;
                w_ldb      = bus.in_valid;
                if (bus.in_valid) begin
                    w_next = ST_COMPARE;
                end
            end

            ST_COMPARE: begin
                // eq wins over the step budget: a run that converges on the
                // very last allowed step still completes.
                if (bus.eq) begin
                    w_next = ST_DONE;
                end else if (w_cnt_tc) begin
                    w_next = ST_ERR;
                end else if (bus.gt) begin
                    w_next = ST_SUB_A;
                end else if (bus.lt) begin
                    w_next = ST_SUB_B;
                end else begin
                    w_next = ST_ERR;
                end
            end

            ST_SUB_A: begin
                w_sel_1  = 1'b1;
                w_sel_in = 1'b1;
                w_lda    = 1'b1;
                w_next   = ST_COMPARE;
            end

            ST_SUB_B: begin
                w_sel_2  = 1'b1;
                w_sel_in = 1'b1;
                w_ldb    = 1'b1;
                w_next   = ST_COMPARE;
            end

            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end

            ST_ERR: begin
                w_err  = 1'b1;
                w_next = ST_IDLE;
            end

            default: begin
                w_busy = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.lda        = w_lda;
    assign bus.ldb        = w_ldb;
    assign bus.sel_1      = w_sel_1;
    assign bus.sel_2      = w_sel_2;
    assign bus.sel_in     = w_sel_in;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.err        = w_err;
    assign bus.iter_count = w_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gcd_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gcd_controller
//  Description : Self-checking bench for gcd_controller. Wraps the DUT with a
//                behavioural 16-bit subtract datapath, runs a directed vector
//                table, hand-written reset / bad-flag sequences and random
//                operands checked against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_controller;
    import gcd_pkg::*;

    localparam int C_CNT_W = 16;
    localparam int C_MAX   = 16;

    logic clk;
    logic rst_n;

    gcd_if #(.CNT_W(C_CNT_W)) bus ();

    gcd_controller #(
        .CNT_W    (C_CNT_W),
        .MAX_ITER (C_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural datapath
    // ------------------------------------------------------------------
    logic [15:0] data_in;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] sub;
    logic        kill_flags;
    int          loads_a;
    int          loads_b;

    assign sub    = (bus.sel_1 ? ra : rb) - (bus.sel_2 ? ra : rb);
    assign bus.gt = !kill_flags && (ra > rb);
    assign bus.lt = !kill_flags && (ra < rb);
    assign bus.eq = !kill_flags && (ra == rb);

    always @(posedge clk) begin
        if (bus.lda) ra <= bus.sel_in ? sub : data_in;
        if (bus.ldb) rb <= bus.sel_in ? sub : data_in;
        if (bus.lda && !bus.sel_in) loads_a = loads_a + 1;
        if (bus.ldb && !bus.sel_in) loads_b = loads_b + 1;
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int total;
    int bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: Euclid by repeated subtraction, bounded by the step budget.
    function automatic void ref_gcd(input int a, input int b, output bit d,
                                    output int n, output int g);
        n = 0;
        d = 0;
        g = 0;
        while (1) begin
            if (a == b) begin
                d = 1;
                g = a;
                return;
            end
            if (n == C_MAX) return;
            if (a > b) a = a - b;
            else       b = b - a;
            n++;
        end
    endfunction

    // One complete run; stall idle cycles precede each operand, start is
    // re-pulsed at cycle poke (0 = never). Cycle 0 is the start cycle.
    task automatic run(input logic [15:0] a, input logic [15:0] b,
                       input int stall, input int poke,
                       input bit exp_done, input int exp_lat,
                       input logic [15:0] exp_res, input int exp_iter,
                       input string tag);
        int  t;
        int  phase;
        int  wcnt;
        int  stall_ready;
        int  la0;
        int  lb0;
        bit  fin;
        logic d;
        logic e;
        logic [15:0] res;
        logic [15:0] it;
        int  lat;
        t = 0; phase = 0; wcnt = 0; stall_ready = 0; fin = 0;
        d = 0; e = 0; res = '0; it = '0; lat = -1;
        la0 = loads_a; lb0 = loads_b;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_valid = 1'b0;
        while (!fin && t < 400) begin
            @(negedge clk);
            t++;
            bus.start = (t == poke);
            if (bus.done || bus.err) begin
                d = bus.done; e = bus.err; lat = t; res = ra; it = bus.iter_count;
                bus.in_valid = 1'b0;
                fin = 1;
            end else if (bus.in_ready && phase < 2) begin
                if (wcnt < stall) begin
                    bus.in_valid = 1'b0;
                    stall_ready++;
                    wcnt++;
                end else begin
                    bus.in_valid = 1'b1;
                    data_in = (phase == 0) ? a : b;
                    phase++;
                    wcnt = 0;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk({tag, " finished"}, 32'(fin), 32'd1);
        chk({tag, " done"}, 32'(d), 32'(exp_done));
        chk({tag, " err"}, 32'(e), 32'(!exp_done));
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " iter_count"}, 32'(it), 32'(exp_iter));
        if (exp_done) chk({tag, " result"}, 32'(res), 32'(exp_res));
        chk({tag, " loads_a"}, 32'(loads_a - la0), 32'd1);
        chk({tag, " loads_b"}, 32'(loads_b - lb0), 32'd1);
        chk({tag, " ready_in_stall"}, 32'(stall_ready), 32'(2 * stall));
        @(negedge clk);
        chk({tag, " busy_after"}, 32'(bus.busy), 32'd0);
        chk({tag, " iter_hold"}, 32'(bus.iter_count), 32'(exp_iter));
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          stall;
        int          poke;
        bit          exp_done;
        int          exp_lat;
        logic [15:0] exp_res;
        int          exp_iter;
    } vec_t;

    vec_t vt[5];

    initial begin
        total = 0; bad = 0;
        loads_a = 0; loads_b = 0;
        kill_flags = 1'b0;
        data_in = '0;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;

        vt[0] = '{16'd12, 16'd8,  0, 0, 1'b1, 8,  16'd4, 2};
        vt[1] = '{16'd9,  16'd9,  0, 0, 1'b1, 4,  16'd9, 0};
        vt[2] = '{16'd0,  16'd0,  0, 0, 1'b1, 4,  16'd0, 0};
        vt[3] = '{16'd7,  16'd0,  0, 5, 1'b0, 36, 16'd0, 16};
        vt[4] = '{16'd48, 16'd18, 3, 0, 1'b1, 18, 16'd6, 4};

        repeat (2) @(negedge clk);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst outputs", {23'd0, bus.lda, bus.ldb, bus.sel_1, bus.sel_2, bus.sel_in,
                            bus.in_ready, bus.done, bus.err, 1'b0}, 32'd0);
        chk("rst iter_count", 32'(bus.iter_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run(vt[i].a, vt[i].b, vt[i].stall, vt[i].poke, vt[i].exp_done,
                vt[i].exp_lat, vt[i].exp_res, vt[i].exp_iter, $sformatf("vec%0d", i));
        end

        // Reset asserted while in SUB_A (cycle 4 of a 12/8 run).
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b1; data_in = 16'd12;
        @(negedge clk);
        data_in = 16'd8;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("midrst in SUB_A", {30'd0, bus.lda, bus.sel_in}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("midrst outputs", {22'd0, bus.busy, bus.lda, bus.ldb, bus.sel_1, bus.sel_2,
                               bus.sel_in, bus.in_ready, bus.done, bus.err, 1'b0}, 32'd0);
        chk("midrst iter_count", 32'(bus.iter_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(16'd12, 16'd8, 0, 0, 1'b1, 8, 16'd4, 2, "post_rst");

        // No comparator flag in COMPARE -> ERR on the next cycle.
        kill_flags = 1'b1;
        run(16'd5, 16'd3, 0, 0, 1'b0, 4, 16'd0, 0, "noflag");
        kill_flags = 1'b0;

        // Random operands against the reference model.
        for (int i = 0; i < 20; i++) begin
            int  a;
            int  b;
            int  n;
            int  g;
            int  st;
            bit  d;
            a  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 60));
            b  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 60));
            st = int'($urandom_range(0, 2));
            ref_gcd(a, b, d, n, g);
            run(16'(a), 16'(b), st, 0, d, 4 + 2 * n + 2 * st, 16'(g), n,
                $sformatf("rnd%0d(%0d,%0d)", i, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
